// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with valid/ready output.
// Reports stop-bit framing errors as a one-cycle pulse and FIFO overflow as a sticky flag.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 12_500_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_rx,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  input  logic                          i_clr
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             armed_q, armed_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic             rx_s;
  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;
  logic             wr_en_c;

  assign rx_s    = rx_s_q;
  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_c   = !empty_c && i_ready;

  // Frame decoder: mid-bit sampling driven by a down-counting baud timer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    armed_d     = armed_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = CNT_W'(DIV / 2 - 1);
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = DATA;
          cnt_d   = CNT_W'(DIV - 1);
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = CNT_W'(DIV - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          // A low stop sample (e.g. a break) must see the line high again before re-arming
          armed_d = rx_s;
          if (rx_s) begin
            push_c = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointers and storage; a push into a full FIFO is legal when a pop frees the head
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    wr_en_c = push_c && (!full_c || pop_c);

    if (wr_en_c) begin
      mem_d[wr_q[AW-1:0]] = shreg_q;
      wr_d                = wr_q + PW'(1);
    end
    if (pop_c) begin
      rd_d = rd_q + PW'(1);
    end
    if (i_clr) begin
      ovf_d = 1'b0;
    end
    if (push_c && full_c && !pop_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b1;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync1_q     <= i_rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mem_q       <= mem_d;
    end
  end

  assign o_data      = mem_q[rd_q[AW-1:0]];
  assign o_valid     = !empty_c;
  assign o_count     = wr_q - rd_q;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo: serial frames are generated at bit level, expected bytes are
// queued by a reference FIFO model and a negedge monitor pops and compares on every handshake.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_rx;
  logic          i_ready;
  logic          i_clr;
  logic [7:0]    o_data;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_frame_err;
  logic          o_overflow;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  int         err_seen = 0;
  logic       exp_ovf = 1'b0;
  int         fall_cyc = 0;
  int         first_valid_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] mon_e;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_frame_err(o_frame_err),
    .o_overflow (o_overflow),
    .i_clr      (i_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every accepted byte must match the head of the reference queue
  always @(negedge clk) begin
    if (rstn) begin
      if (o_frame_err) err_seen++;
      if (o_valid && !valid_prev) first_valid_cyc = cyc;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%02h, required no byte", o_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_data", int'(o_data), int'(mon_e));
        end
      end
    end
    valid_prev = o_valid;
  end

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a good frame enters the FIFO unless it already holds DEPTH bytes
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (exp_q.size() < int'(DEPTH)) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_err++;
    end
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    i_rx = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    rstn    = 1'b0;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    i_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_count", int'(o_count), 0);
    check("rst_frame_err", int'(o_frame_err), 0);
    check("rst_overflow", int'(o_overflow), 0);
    rstn = 1'b1;
    idle(3);

    // Single byte with consumer always ready: latency from start edge to o_valid
    send_frame(8'h55, 1'b1);
    idle(3);
    check_range("latency_0x55", first_valid_cyc - fall_cyc, 97, 99);
    check("count_after_0x55", int'(o_count), 0);
    check("frame_err_0x55", err_seen, exp_err);

    // Back-to-back bytes held by a stalled consumer
    i_ready = 1'b0;
    send_frame(8'h41, 1'b1);
    idle(1);
    check("count_step1", int'(o_count), exp_q.size());
    send_frame(8'h42, 1'b1);
    idle(1);
    check("count_step2", int'(o_count), exp_q.size());
    send_frame(8'h43, 1'b1);
    idle(1);
    check("count_step3", int'(o_count), 3);
    check("head_held", int'(o_data), int'(exp_q[0]));
    for (int i = 0; i < 3; i++) begin
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
      idle(3);
    end
    check("count_after_pulses", int'(o_count), 0);
    i_ready = 1'b1;

    // Bad stop bit, then a good byte
    send_frame(8'hA5, 1'b0);
    idle(4);
    check("frame_err_once", err_seen, exp_err);
    check("count_after_bad", int'(o_count), 0);
    send_frame(8'h3C, 1'b1);
    drain();

    // One-cycle low glitch while idle
    i_rx = 1'b0;
    @(posedge clk);
    #1;
    idle(3 * DIV);
    check("glitch_no_valid", int'(o_valid), 0);
    check("glitch_no_err", err_seen, exp_err);

    // Break: line low well past one frame decodes as a single framing error
    exp_err++;
    i_rx = 1'b0;
    repeat (12 * DIV) @(posedge clk);
    #1;
    idle(20);
    check("break_err", err_seen, exp_err);
    check("break_no_push", int'(o_count), 0);
    send_frame(8'h99, 1'b1);
    drain();

    // Overflow: five bytes into a four-entry FIFO with no consumer
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      idle(2);
    end
    check("ovf_count_full", int'(o_count), exp_q.size());
    check("ovf_flag_set", int'(o_overflow), int'(exp_ovf));
    check("ovf_head_first", int'(o_data), int'(exp_q[0]));
    i_clr = 1'b1;
    @(posedge clk);
    #1;
    i_clr = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", int'(o_overflow), int'(exp_ovf));
    i_ready = 1'b1;
    drain();

    // Reset in the middle of a frame: the partial byte is lost
    i_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    i_rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    i_rx = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rstn = 1'b0;
    i_rx = 1'b1;
    #2;
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_count", int'(o_count), 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3);
    send_frame(8'h7E, 1'b1);
    drain();
    check("midrst_no_err", err_seen, exp_err);

    // Randomized frames, some with bad stop bits, random idle gaps
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      if (ok) idle(int'($urandom_range(0, 8)));
      else idle(3 + int'($urandom_range(0, 8)));
    end
    idle(5);
    drain();
    check("rand_err_total", err_seen, exp_err);
    check("rand_count_end", int'(o_count), 0);
    check("final_overflow", int'(o_overflow), int'(exp_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver with an output FIFO that consumes the serial stream from the core's o_uart_tx in the simulation top, or a board RX pin.
- Decodes 8N1 frames into bytes and buffers them in a first-word-fall-through FIFO with a valid/ready output.
- Benches and the ViDBo front end use it to read console output without a behavioural decoder.
- Reports framing errors and FIFO overflow.

Parameters:
- CLK_FREQ_HZ, 12_500_000, core clock frequency in Hz (matches the core's clk_freq_hz).
- BAUD, 115200, line rate. DIV = CLK_FREQ_HZ/BAUD, truncated (108 at defaults). DIV must be >= 4.
- FIFO_DEPTH, 16, byte entries. Must be a power of 2 and >= 2.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- i_rx  in  1  serial input, idle high (connect to o_uart_tx)
- o_data  out  8  byte at FIFO head
- o_valid  out  1  FIFO not empty
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready
- o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_frame_err  out  1  one-cycle pulse on bad stop bit
- o_overflow  out  1  sticky; set when a good byte arrives while the FIFO is full
- i_clr  in  1  synchronous clear of o_overflow

Behaviour:
- Reset values:
  - o_data 0, o_valid 0, o_count 0, o_frame_err 0, o_overflow 0.
  - Synchronizer flops reset to 1 (idle line). FSM in IDLE. Pointers 0. Baud counter 0. Bit index 0.
- i_rx passes through a 2-flop synchronizer; rx_s is the second flop. All decoding uses rx_s.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On rx_s == 0, go to START and load the baud counter with DIV/2-1.
- START:
  - Count down. At 0, sample rx_s.
  - If 1 (glitch), return to IDLE with no output.
  - If 0, load DIV-1, clear the bit index, go to DATA.
- DATA:
  - At each counter expiry, shift rx_s in LSB-first and reload DIV-1.
  - After the 8th sample, go to STOP.
- STOP:
  - At counter expiry, sample rx_s.
  - If 1, push the byte. If 0, pulse o_frame_err for exactly one cycle and discard the byte.
  - Either way, return to IDLE in the same cycle.
  - A following start bit is detected from the next cycle on; no wait for mid-stop is required beyond this.
- Push:
  - Byte is written on the stop-sample cycle. o_valid/o_data reflect it the next cycle if the FIFO was empty (FWFT).
- Pop:
  - Occurs on o_valid & i_ready. Head advances the next cycle.
  - o_data holds its value while o_valid & !i_ready.
- Simultaneous push and pop:
  - Both take effect; o_count is unchanged.
  - When full, a push coincident with a pop is accepted, not an overflow.
- Push while full without a pop: byte dropped, o_overflow set and held.
- o_overflow clears on i_clr. If i_clr and a new overflow coincide, set wins.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are decoded from the MSB difference.
- o_count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Reset mid-frame: everything returns to reset values immediately (async). A partial frame is lost. Stale FIFO contents are invisible (o_valid 0).
- Line held low (break): decodes as 0x00 with a framing error, then stays in IDLE until rx_s returns high and falls again.
  - IDLE arms only after seeing rx_s == 1 at least once since the last STOP.

Test Plan:
- CLK_FREQ_HZ=1_000_000, BAUD=100_000 (DIV=10), i_ready=1. Send 0x55 8N1 → o_valid high for one cycle with o_data=0x55, 97–99 cycles after i_rx falls. o_frame_err stays 0.
- i_ready=0. Send 0x41, 0x42, 0x43 back-to-back → o_count steps 1, 2, 3. o_data=0x41 held. Then pulse i_ready 3 times → bytes 0x41, 0x42, 0x43 in order, o_count returns to 0.
- Send 0xA5 with the stop bit driven 0 → o_frame_err pulses exactly once, o_count stays 0. A following good 0x3C is received correctly.
- 1-cycle low glitch on i_rx in idle → no START progression past mid-bit, no push, no error.
- FIFO_DEPTH=4, i_ready=0. Send 5 bytes → o_count=4 and o_overflow=1. Head byte is the first sent; the 5th is dropped. Pulse i_clr → o_overflow 0.
- Assert rstn=0 during DATA of a frame, release, then send 0x7E → only 0x7E appears. o_frame_err=0 throughout.
